// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared definitions for the AES inverse-cipher controller:
//   - block width and round-count constants for AES-128/192/256
//   - aes_block_t: 128-bit state. Byte 0 occupies bits [0:7] and bytes are
//     stored column-major, so byte i is row i%4, column i/4.
//   - aes_state_e: controller FSM states
//   - GF(2^8) helpers (reduction polynomial 0x11b), the inverse S-box and
//     InvShiftRows.
//   Configuration macro used by the controller: AES_INV_CTRL_ABORT_EN.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NR_AES128   = 10;
    localparam int NR_AES192   = 12;
    localparam int NR_AES256   = 14;

    typedef logic [0:AES_BLOCK_W-1] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } aes_state_e;

    // Inverse S-box. Entry 0 is the most significant byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = gf_xtime(gf_xtime(gf_xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = gf_xtime(b);
        x8 = gf_xtime(gf_xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = gf_xtime(gf_xtime(b));
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    // Row r is rotated right by r columns: out[r][c] = in[r][(c-r) mod 4].
    function automatic aes_block_t inv_shift_rows(input aes_block_t s);
        aes_block_t r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c - row + 4) % 4)) +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_dp.sv
// aes_inv_round_dp
//   Combinational AES inverse round, shared by every iteration.
//   next_state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk)
//   or, with last_round set, InvSubBytes(InvShiftRows(state)) ^ rk.
// Ports:
//   state      in   current 128-bit state
//   rk         in   round key for this round
//   last_round in   bypass InvMixColumns
//   next_state out  state after the round
module aes_inv_round_dp
    import aes_pkg::*;
(
    input  aes_block_t state,
    input  aes_block_t rk,
    input  logic       last_round,
    output aes_block_t next_state
);

    aes_block_t sr;
    aes_block_t ark;
    aes_block_t mc;

    assign sr = inv_shift_rows(state);

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign ark[8*i +: 8] = inv_sbox(sr[8*i +: 8]) ^ rk[8*i +: 8];
    end

    // Each output byte of a column: 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3].
    for (genvar c = 0; c < 4; c++) begin : g_mix
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign mc[8*(4*c + r) +: 8] =
                gf_mul14(ark[8*(4*c + r)           +: 8]) ^
                gf_mul11(ark[8*(4*c + (r + 1) % 4) +: 8]) ^
                gf_mul13(ark[8*(4*c + (r + 2) % 4) +: 8]) ^
                gf_mul9 (ark[8*(4*c + (r + 3) % 4) +: 8]);
        end
    end

    assign next_state = last_round ? ark : mc;

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl
//   Iterative AES inverse-cipher sequencer: one round per clock through
//   aes_inv_round_dp, round keys read combinationally via rk_idx/rk_data.
//   Plaintext is valid NR+1 cycles after the accept cycle; one block in
//   flight at a time.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   abort                 (only with AES_INV_CTRL_ABORT_EN) drop the block
//   in_valid/in_ready     ciphertext handshake, in_data ciphertext
//   rk_idx/rk_data        round-key index out, key back same cycle
//   out_valid/out_ready   plaintext handshake, out_data plaintext
//   busy                  FSM not idle
// Macro: AES_INV_CTRL_ABORT_EN adds the abort input.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = NR_AES128,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_INV_CTRL_ABORT_EN
    input  logic                abort,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:127]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [0:127]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:127]        out_data,
    output logic                busy
);

    if (NR < 2) begin : g_bad_nr
        $error("aes_inv_cipher_ctrl: NR must be at least 2");
    end
    if (NR >= (1 << RK_IDX_W)) begin : g_bad_idx_w
        $error("aes_inv_cipher_ctrl: RK_IDX_W too narrow for NR");
    end

    aes_state_e          fsm_state;
    logic [RK_IDX_W-1:0] cnt;
    aes_block_t          state_reg;
    aes_block_t          dp_next;

    aes_inv_round_dp u_dp (
        .state      (state_reg),
        .rk         (rk_data),
        .last_round (fsm_state == ST_FINAL),
        .next_state (dp_next)
    );

    // Outputs are registered, so each one is loaded with the value it must
    // carry in the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= ST_IDLE;
            cnt       <= '0;
            state_reg <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            rk_idx    <= RK_IDX_W'(NR);
        end else begin
            unique case (fsm_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data ^ rk_data;
                        cnt       <= RK_IDX_W'(NR - 1);
                        rk_idx    <= RK_IDX_W'(NR - 1);
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        fsm_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_reg <= dp_next;
                    if (cnt == RK_IDX_W'(1)) begin
                        rk_idx    <= '0;
                        fsm_state <= ST_FINAL;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        rk_idx <= cnt - 1'b1;
                    end
                end
                ST_FINAL: begin
                    state_reg <= dp_next;
                    out_data  <= dp_next;
                    out_valid <= 1'b1;
                    rk_idx    <= RK_IDX_W'(NR);
                    fsm_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm_state <= ST_IDLE;
                    end
                end
                default: fsm_state <= ST_IDLE;
            endcase
`ifdef AES_INV_CTRL_ABORT_EN
            // Overrides the case above; a handshake in the same DONE cycle
            // still completes because out_valid was already high.
            if (abort && fsm_state != ST_IDLE) begin
                state_reg <= '0;
                cnt       <= '0;
                out_valid <= 1'b0;
                out_data  <= '0;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
                rk_idx    <= RK_IDX_W'(NR);
                fsm_state <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl
//   Self-checking bench. Reference: a forward AES cipher built from GF(2^8)
//   arithmetic (S-box derived from field inverse + affine map); plaintexts
//   are encrypted by the bench and must come back out of the DUT.
//   Works with or without AES_INV_CTRL_ABORT_EN.
module tb_aes_inv_cipher_ctrl;

    localparam int NR       = 10;
    localparam int RK_IDX_W = 4;
    typedef logic [0:127] blk_t;

    localparam blk_t FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam blk_t FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid, in_ready, out_valid, out_ready, busy;
    blk_t in_data, rk_data, out_data;
    logic [RK_IDX_W-1:0] rk_idx;
`ifdef AES_INV_CTRL_ABORT_EN
    logic abort;
`endif

    blk_t       rk_ram [0:NR];
    logic [7:0] sb [256];
    int checks = 0, fails = 0, hs_cnt = 0, cyc = 0, nblk = 0;

    aes_inv_cipher_ctrl #(.NR(NR), .RK_IDX_W(RK_IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AES_INV_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rk_data = (int'(rk_idx) <= NR) ? rk_ram[rk_idx] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic blk_t rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Forward AES with the round keys currently in rk_ram.
    function automatic blk_t encrypt(input blk_t pt);
        blk_t s, t;
        logic [7:0] a [4];
        s = pt ^ rk_ram[0];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++)
                t[8*i +: 8] = sb[s[8*(i % 4 + 4*((i / 4 + i % 4) % 4)) +: 8]];
            if (r < NR) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = t[8*(4*c + k) +: 8];
                    for (int k = 0; k < 4; k++)
                        t[8*(4*c + k) +: 8] = gmul(a[k], 8'h02) ^ gmul(a[(k + 1) % 4], 8'h03)
                                              ^ a[(k + 2) % 4] ^ a[(k + 3) % 4];
                end
            end
            s = t ^ rk_ram[r];
        end
        return s;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    task automatic load_fips_keys();
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        w[0] = 32'h00010203; w[1] = 32'h04050607;
        w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_ram[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Full transaction from an IDLE negedge to the negedge after the output
    // handshake. acc returns the cycle stamp of the accept cycle.
    task automatic do_block(input blk_t ct, input blk_t pt, input int stall,
                            input bit keep_valid, input string tag, output int acc);
        int n, lat;
        blk_t held;
        in_data = ct; in_valid = 1'b1; out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        acc = cyc;
        chk({tag, " accept"}, 128'(in_ready), 128'(1));
        if (!in_ready) return;
        chk({tag, " rk_idle"}, 128'(rk_idx), 128'(NR));
        @(negedge clk);
        lat = 1;
        if (!keep_valid) in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            chk({tag, " rk_idx"}, 128'(rk_idx), 128'((lat < NR) ? NR - lat : 0));
            chk({tag, " busy/in_ready"}, 128'({busy, in_ready}), 128'(2'b10));
            in_data = rnd();
            @(negedge clk); lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(NR + 1));
        chk({tag, " out_data"}, out_data, pt);
        held = out_data;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1; in_data = rnd();
            @(negedge clk);
            chk({tag, " hold v/rdy"}, 128'({out_valid, in_ready}), 128'(2'b10));
            chk({tag, " hold data"}, out_data, held);
        end
        out_ready = 1'b1; in_valid = keep_valid;
        @(negedge clk);
        chk({tag, " post v/rdy/busy"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
        chk({tag, " post data"}, out_data, 128'(0));
        nblk++;
    endtask

    initial begin
        int a1, a2, n, npulse, hs0;
        blk_t pt, ct;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef AES_INV_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        build_sbox();
        load_fips_keys();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst v/busy", 128'({out_valid, busy}), 128'(0));
        chk("rst data", out_data, 128'(0));
        chk("rst rk_idx", 128'(rk_idx), 128'(NR));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel in_ready", 128'(in_ready), 128'(1));

        // FIPS-197 C.1, then back-pressure, then back-to-back blocks.
        do_block(FIPS_CT, FIPS_PT, 0, 1'b0, "fips", a1);
        do_block(FIPS_CT, FIPS_PT, 6, 1'b0, "bp", a1);
        pt = rnd(); ct = encrypt(pt);
        do_block(FIPS_CT, FIPS_PT, 0, 1'b1, "b2b1", a1);
        do_block(ct, pt, 0, 1'b0, "b2b2", a2);
        chk("b2b spacing", 128'(a2 - a1), 128'(NR + 2));

        // Reset during round 5 (rk_idx==5).
        in_data = FIPS_CT; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("r5 rk_idx", 128'(rk_idx), 128'(5));
        #2 rst_n = 1'b0; #1;
        chk("r5 v/busy", 128'({out_valid, busy}), 128'(0));
        chk("r5 rk_idx rst", 128'(rk_idx), 128'(NR));
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        do_block(FIPS_CT, FIPS_PT, 0, 1'b0, "after_rst", a1);

        // Reset while plaintext is being held in DONE.
        in_data = FIPS_CT; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk("rdone data", out_data, FIPS_PT);
        #2 rst_n = 1'b0; #1;
        chk("rdone v/busy", 128'({out_valid, busy}), 128'(0));
        chk("rdone data rst", out_data, 128'(0));
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; @(negedge clk);

        // Random round keys and plaintexts.
        for (int r = 0; r <= NR; r++) rk_ram[r] = rnd();
        for (int b = 0; b < 12; b++) begin
            pt = rnd(); ct = encrypt(pt);
            do_block(ct, pt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand", a1);
        end

`ifdef AES_INV_CTRL_ABORT_EN
        // Abort during round 3: no plaintext pulse afterwards.
        pt = rnd(); ct = encrypt(pt);
        in_data = ct; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        n = 0;
        while (int'(rk_idx) != NR - 3 && n < 40) begin @(negedge clk); n++; end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("ab3 busy/rdy/v", 128'({busy, in_ready, out_valid}), 128'(3'b010));
        npulse = 0;
        repeat (NR + 3) begin @(negedge clk); if (out_valid) npulse++; end
        chk("ab3 no pulse", 128'(npulse), 128'(0));

        // Abort coincident with the output handshake: counted exactly once.
        in_data = ct; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk("abhs data", out_data, pt);
        hs0 = hs_cnt;
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abhs v/rdy/busy", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        chk("abhs count", 128'(hs_cnt - hs0), 128'(1));
        nblk++;
        pt = rnd(); ct = encrypt(pt);
        do_block(ct, pt, 1, 1'b0, "after_abort", a1);
`endif

        chk("handshakes", 128'(hs_cnt), 128'(nblk));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
